mem_port_arbiter: RTL and testbench

//   Shares the core's single-port unified memory (Mem) between the IF-stage

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, data port and memory port that meet at the
//   mem_port_arbiter.
//   slave  : the arbiter's view. It receives requests and mem_rdata, and drives
//            grants, responses and the memory strobes.
//   master : the core/memory view, which is the mirror image of the slave.
//   Parameters AW and DW must match the arbiter instance that uses the bus.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   load/store port. It issues at most one access per clock. The data port
//   wins by default. The fetch port is forced through after STARVE_MAX data
//   grants in a row while it waits. Fetch is never granted while the core is
//   halted. Reads in flight are tracked by a MEM_LAT-deep tag pipe, which
//   routes mem_rdata back to the port that issued each read.
// Ports
//   clk1       : clock, rising edge
//   rst_n      : synchronous active-low reset
//   halted     : core halted, blocks fetch grants
//   bus        : fetch/data/memory signals (mem_port_arbiter_if.slave)
//   if_stall   : fetch requested but not granted this cycle
//   starve_cnt : consecutive data grants while fetch waits
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   halted,
  mem_port_arbiter_if.slave      bus,
  output logic                   if_stall,
  output logic [3:0]             starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic               fetch_ok;
  logic               grant_if;
  logic               grant_dm;
  logic               rd_grant;
  logic [3:0]         starve_q;
  logic [3:0]         starve_d;
  logic [MEM_LAT-1:0] tag_valid;
  logic [MEM_LAT-1:0] tag_owner;
  logic               tail_valid;

  assign fetch_ok = bus.if_req & ~halted;

  // Pick at most one winner. Reset holding low masks every grant, so nothing
  // reaches the memory while the block is being reset.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (rst_n) begin
      if (bus.dm_req && fetch_ok) begin
        if (starve_q < STARVE_LIM) grant_dm = 1'b1;
        else                       grant_if = 1'b1;
      end else if (bus.dm_req) begin
        grant_dm = 1'b1;
      end else if (fetch_ok) begin
        grant_if = 1'b1;
      end
    end
  end

  // Memory side follows the winner in the same cycle.
  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.mem_en    = grant_if | grant_dm;
  assign bus.mem_we    = grant_dm & bus.dm_we;
  assign bus.mem_addr  = grant_dm ? bus.dm_addr : bus.if_addr;
  assign bus.mem_wdata = bus.dm_wdata;

  assign if_stall   = rst_n & bus.if_req & ~grant_if;
  assign starve_cnt = rst_n ? starve_q : 4'd0;

  // Starvation counter: it counts data wins only while fetch is actually
  // waiting, and saturates at the limit. A halted fetch therefore still
  // counts but cannot be granted, so the counter stays at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_if || !bus.if_req) starve_d = 4'd0;
    else if (grant_dm && starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
  end

  // Stores send no response, so only read grants enter the tag pipe as valid.
  assign rd_grant = grant_if | (grant_dm & ~bus.dm_we);

  // Register state. The tag pipe shifts every cycle, so a tag reaches the
  // tail exactly MEM_LAT cycles after its grant, in step with mem_rdata.
  // Clearing it on reset drops any reads that are still in flight.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      starve_q  <= 4'd0;
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      starve_q  <= starve_d;
      tag_valid <= (tag_valid << 1) | MEM_LAT'(rd_grant);
      tag_owner <= (tag_owner << 1) | MEM_LAT'(grant_dm);
    end
  end

  // Response routing: tag_owner is 1 for the data port and 0 for fetch.
  assign tail_valid    = rst_n & tag_valid[MEM_LAT-1];
  assign bus.if_rvalid = tail_valid & ~tag_owner[MEM_LAT-1];
  assign bus.dm_rvalid = tail_valid &  tag_owner[MEM_LAT-1];
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Runs two arbiters side by side on the same stimulus: one with MEM_LAT=1 and
//   one with MEM_LAT=3. Each has its own memory model. A table of directed
//   vectors drives the MEM_LAT=1 instance and checks it. Hand-written
//   sequences cover the MEM_LAT=3 response latency and the reset that arrives
//   while a read is in flight.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic halted = 1'b0;
  logic if_stall1, if_stall3;
  logic [3:0] starve1, starve3;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter_if #(.AW(10), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(10), .DW(32)) bus3 ();

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .bus(bus1),
    .if_stall(if_stall1), .starve_cnt(starve1)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .bus(bus3),
    .if_stall(if_stall3), .starve_cnt(starve3)
  );

  always #5 clk1 = ~clk1;

  // Initial memory contents: word i holds a5000000|i, and word 8 holds
  // fc000000.
  function automatic logic [31:0] initWord(input int i);
    return (i == 8) ? 32'hFC00_0000 : (32'hA500_0000 | 32'(i));
  endfunction

  // Memory models. Each memory is filled once on the first edge and then
  // behaves as a synchronous single-port RAM. The first model has 1 cycle of
  // read latency and the second has 3.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic        mem_ready = 1'b0;
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];

  always @(posedge clk1) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] <= initWord(i);
        mem3[i] <= initWord(i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
    end
    rd1    <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr] : 32'h0;
    rd3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr] : 32'h0;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign bus1.mem_rdata = rd1;
  assign bus3.mem_rdata = rd3[2];

  // One directed vector: the inputs, then the expected outputs of the
  // MEM_LAT=1 instance for the same cycle.
  typedef struct {
    logic        rst_n, halted, if_req;
    logic [9:0]  if_addr;
    logic        dm_req, dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we;
    logic [9:0]  e_addr;
    logic        e_stall;
    logic [3:0]  e_starve;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_dm_rv;
    logic [31:0] e_dm_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(
    input logic r, h, ifr, input logic [9:0] ifa,
    input logic dmr, dmw, input logic [9:0] dma, input logic [31:0] dmwd,
    input logic ig, dg, en, we, input logic [9:0] ea, input logic st,
    input logic [3:0] sc, input logic ivr, input logic [31:0] ird,
    input logic dvr, input logic [31:0] drd);
    vec_t v;
    v.rst_n = r; v.halted = h; v.if_req = ifr; v.if_addr = ifa;
    v.dm_req = dmr; v.dm_we = dmw; v.dm_addr = dma; v.dm_wdata = dmwd;
    v.e_if_gnt = ig; v.e_dm_gnt = dg; v.e_mem_en = en; v.e_mem_we = we;
    v.e_addr = ea; v.e_stall = st; v.e_starve = sc;
    v.e_if_rv = ivr; v.e_if_rd = ird; v.e_dm_rv = dvr; v.e_dm_rd = drd;
    vecs.push_back(v);
  endtask

  // Drive the same inputs onto both instances.
  task automatic setIn(input logic r, h, ifr, input logic [9:0] ifa,
                       input logic dmr, dmw, input logic [9:0] dma,
                       input logic [31:0] dmwd);
    rst_n = r; halted = h;
    bus1.if_req = ifr; bus1.if_addr = ifa; bus1.dm_req = dmr;
    bus1.dm_we = dmw; bus1.dm_addr = dma; bus1.dm_wdata = dmwd;
    bus3.if_req = ifr; bus3.if_addr = ifa; bus3.dm_req = dmr;
    bus3.dm_we = dmw; bus3.dm_addr = dma; bus3.dm_wdata = dmwd;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk1);
    #1;
    setIn(v.rst_n, v.halted, v.if_req, v.if_addr, v.dm_req, v.dm_we,
          v.dm_addr, v.dm_wdata);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge clk1);
    chk("if_gnt",     idx, 32'(bus1.if_gnt),    32'(v.e_if_gnt));
    chk("dm_gnt",     idx, 32'(bus1.dm_gnt),    32'(v.e_dm_gnt));
    chk("mem_en",     idx, 32'(bus1.mem_en),    32'(v.e_mem_en));
    chk("mem_we",     idx, 32'(bus1.mem_we),    32'(v.e_mem_we));
    if (v.e_mem_en)
      chk("mem_addr", idx, 32'(bus1.mem_addr),  32'(v.e_addr));
    chk("if_stall",   idx, 32'(if_stall1),      32'(v.e_stall));
    chk("starve_cnt", idx, 32'(starve1),        32'(v.e_starve));
    chk("if_rvalid",  idx, 32'(bus1.if_rvalid), 32'(v.e_if_rv));
    chk("if_rdata",   idx, bus1.if_rdata,       v.e_if_rd);
    chk("dm_rvalid",  idx, 32'(bus1.dm_rvalid), 32'(v.e_dm_rv));
    chk("dm_rdata",   idx, bus1.dm_rdata,       v.e_dm_rd);
  endtask

  initial begin
    setIn(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with both ports requesting: nothing may leak out.
    for (int k = 0; k < 3; k++)
      addVec(0,0,1,0, 1,0,3,0,  0,0,0,0,0,0,0, 0,0, 0,0);

    // Fetch-only stream over addresses 0..8, with each word returning a cycle
    // later.
    for (int k = 0; k < 9; k++)
      addVec(1,0,1,10'(k), 0,0,0,0,  1,0,1,0,10'(k),0,0,
             k > 0, (k > 0) ? initWord(k-1) : 32'h0, 0,0);
    addVec(1,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0, 1,32'hFC00_0000, 0,0);

    // Contention: four data wins, then fetch is forced through.
    for (int k = 0; k < 4; k++)
      addVec(1,0,1,20, 1,0,30,0,  0,1,1,0,30,1,4'(k), 0,0,
             k > 0, (k > 0) ? 32'hA500_001E : 32'h0);
    addVec(1,0,1,20, 1,0,30,0,  1,0,1,0,20,0,4, 0,0, 1,32'hA500_001E);
    addVec(1,0,1,20, 1,0,30,0,  0,1,1,0,30,1,0, 1,32'hA500_0014, 0,0);
    addVec(1,0,0,0,  0,0,0,0,   0,0,0,0,0,0,1, 0,0, 1,32'hA500_001E);

    // A store, then a load of the same word on the next cycle.
    addVec(1,0,0,0, 1,1,5,32'h0000_002D,  0,1,1,1,5,0,0, 0,0, 0,0);
    addVec(1,0,0,0, 1,0,5,0,              0,1,1,0,5,0,0, 0,0, 0,0);
    addVec(1,0,0,0, 0,0,0,0,              0,0,0,0,0,0,0, 0,0, 1,32'h0000_002D);
    addVec(1,0,0,0, 0,0,0,0,              0,0,0,0,0,0,0, 0,0, 0,0);

    // Halted: fetch is blocked while a load still gets through. After that,
    // halted rises while a fetch is in flight.
    addVec(1,1,1,2, 1,0,8,0,  0,1,1,0,8,1,0, 0,0, 0,0);
    addVec(1,1,1,2, 0,0,0,0,  0,0,0,0,0,1,1, 0,0, 1,32'hFC00_0000);
    addVec(1,1,1,2, 0,0,0,0,  0,0,0,0,0,1,1, 0,0, 0,0);
    addVec(1,0,1,2, 0,0,0,0,  1,0,1,0,2,0,1, 0,0, 0,0);
    addVec(1,1,0,0, 0,0,0,0,  0,0,0,0,0,0,0, 1,32'hA500_0002, 0,0);
    addVec(1,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0);

    // Halted fetch waiting behind steady loads: the counter saturates at 4.
    for (int k = 0; k < 6; k++)
      addVec(1,1,1,2, 1,0,1,0,  0,1,1,0,1,1,(k < 4) ? 4'(k) : 4'd4, 0,0,
             k > 0, (k > 0) ? 32'hA500_0001 : 32'h0);
    addVec(1,0,0,0, 0,0,0,0,  0,0,0,0,0,0,4, 0,0, 1,32'hA500_0001);
    addVec(1,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0);
    addVec(1,0,0,0, 0,0,0,0,  0,0,0,0,0,0,0, 0,0, 0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // MEM_LAT=3: a load returns exactly three cycles after its grant.
    @(posedge clk1); #1; setIn(1,0,0,0, 1,0,6,0);
    @(negedge clk1); chk("lat3_dm_gnt", 100, 32'(bus3.dm_gnt), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk1); #1; setIn(1,0,0,0, 0,0,0,0);
      @(negedge clk1);
      chk("lat3_dm_rvalid", 100 + k, 32'(bus3.dm_rvalid), 32'(k == 3));
      chk("lat3_dm_rdata",  100 + k, bus3.dm_rdata,
          (k == 3) ? 32'hA500_0006 : 32'h0);
      chk("lat3_if_rvalid", 100 + k, 32'(bus3.if_rvalid), 32'd0);
    end

    // MEM_LAT=3: reset on the cycle after a load grant drops that load.
    @(posedge clk1); #1; setIn(1,0,0,0, 1,0,4,0);
    @(negedge clk1); chk("rst_flight_gnt", 200, 32'(bus3.dm_gnt), 32'd1);
    @(posedge clk1); #1; setIn(0,0,0,0, 0,0,0,0);
    @(negedge clk1); chk("rst_flight_rvalid", 201, 32'(bus3.dm_rvalid), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk1); #1; setIn(1,0,0,0, 0,0,0,0);
      @(negedge clk1);
      chk("rst_flight_rvalid", 200 + k, 32'(bus3.dm_rvalid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
